change_dispenser: RTL

- Coin-output side of the vending machine: the transmitter counterpart of the controller's coin-acceptance input.
- Takes a change amount in 0.5-yuan units from the controller's charge path.
- Emits a greedy sequence of timed one-hot coin pulses (5 / 1 / 0.5 yuan) toward the dispenser hardware.
- Pulse encoding is identical to the controller's coin input, so its output can loop back for self-test.

---
 rtl/vending_pkg.sv | 31 +++
 rtl/pulse_timer.sv | 34 +++
 rtl/change_dispenser.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// ============================================================================
// Module      : vending_pkg
// Description : Coin encodings, coin values and dispenser state type shared by
//               the vending controller and the change dispenser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

  // One-hot coin pulse encoding, common to coin input and coin output
  localparam logic [2:0] COIN_HALF = 3'b001;
  localparam logic [2:0] COIN_ONE  = 3'b010;
  localparam logic [2:0] COIN_FIVE = 3'b100;

  // Coin values in 0.5-yuan units
  localparam int VAL_HALF = 1;
  localparam int VAL_ONE  = 2;
  localparam int VAL_FIVE = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_timer.sv
// ============================================================================
// Module      : pulse_timer
// Description : Loadable down-counter with zero flag; times pulse and gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module      : change_dispenser
// Description : Greedy change payout as timed one-hot coin pulses (5/1/0.5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W     = 6,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             abort,
  output logic [2:0]       coin_out,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] remaining
);

  localparam int c_MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int c_TMR_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
  // Loaded with N-1 so the zero flag is seen on the N-th cycle of the interval
  localparam logic [c_TMR_W-1:0] c_PULSE_LD = c_TMR_W'(PULSE_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_GAP_LD   = c_TMR_W'(GAP_CYC - 1);

  disp_state_t      r_state;
  logic [2:0]       r_coin_out;
  logic             r_busy;
  logic             r_done;
  logic [AMT_W-1:0] r_remaining;
  logic             r_abort_pend;

  logic               w_tmr_load;
  logic [c_TMR_W-1:0] w_tmr_val;
  logic               w_tmr_zero;

  always_comb begin
    w_tmr_load = (r_state == ST_SELECT) || ((r_state == ST_PULSE) && w_tmr_zero);
    w_tmr_val  = (r_state == ST_SELECT) ? c_PULSE_LD : c_GAP_LD;
  end

  pulse_timer #(
    .WIDTH (c_TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_coin_out   <= 3'b000;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_remaining  <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done       <= 1'b0;
          r_abort_pend <= 1'b0;
          if (start) begin
            r_remaining <= amount;
            r_busy      <= 1'b1;
            r_state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (abort) begin
            r_coin_out   <= 3'b000;
            r_busy       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (r_remaining >= AMT_W'(VAL_FIVE)) begin
            r_coin_out  <= COIN_FIVE;
            r_remaining <= r_remaining - AMT_W'(VAL_FIVE);
            r_state     <= ST_PULSE;
          end else if (r_remaining >= AMT_W'(VAL_ONE)) begin
            r_coin_out  <= COIN_ONE;
            r_remaining <= r_remaining - AMT_W'(VAL_ONE);
            r_state     <= ST_PULSE;
          end else if (r_remaining == AMT_W'(VAL_HALF)) begin
            r_coin_out  <= COIN_HALF;
            r_remaining <= '0;
            r_state     <= ST_PULSE;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_PULSE: begin
          // An abort during the pulse is deferred so the coin is never truncated
          if (w_tmr_zero) begin
            r_coin_out <= 3'b000;
            if (abort || r_abort_pend) begin
              r_busy       <= 1'b0;
              r_abort_pend <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end else if (abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        ST_GAP: begin
          if (abort) begin
            r_busy       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (w_tmr_zero) begin
            r_state <= ST_SELECT;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_coin_out <= 3'b000;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign coin_out  = r_coin_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign remaining = r_remaining;

endmodule

`default_nettype wire
